instr_decode: RTL and testbench

//  Command decoder directly downstream of the SPI bridge. Consumes the bridge's byte stream
//  (byte_sync/data_in) and turns each CS-framed transaction into one register-file access.
//  The first byte is the command; for a write, the second byte is the data. For a read, the

---
 rtl/instr_decode.sv | 131 +++++++++++++
 tb/tb_instr_decode.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode.sv
// SPI command decoder: turns each CS-framed byte transaction from the bridge into one register access.
// Optional `INSTR_DECODE_ERR_EN adds a sticky err flag, readable and cleared through address 0.
module instr_decode #(
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned ADDR_MAX = 63
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              byte_sync,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic              hl,
    output logic [7:0]        data_write,
    input  logic [7:0]        data_read
`ifdef INSTR_DECODE_ERR_EN
    ,
    output logic              err
`endif
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_DATA  = 3'd1,
        RD_ISSUE = 3'd2,
        RD_CAP   = 3'd3,
        RD_HOLD  = 3'd4
    } state_t;

    state_t state_r;
    logic   byte_sync_q_r;
    logic   bad_r;
    logic   ev_s;
    logic   cmd_bad_s;
    logic   unused_s;

    function automatic logic addr_bad_f(input logic [ADDR_W-1:0] a);
        return 32'(a) > ADDR_MAX;
    endfunction

    // Rising edge of byte_sync is the only thing that counts as a byte.
    assign ev_s      = byte_sync & ~byte_sync_q_r;
    assign cmd_bad_s = addr_bad_f(data_in[ADDR_W-1:0]);
    assign unused_s  = ^data_in;

    // Frame FSM; every output is a flop so the register file sees glitch-free strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            byte_sync_q_r <= 1'b0;
            bad_r         <= 1'b0;
            data_out      <= 8'h00;
            read          <= 1'b0;
            write         <= 1'b0;
            addr          <= {ADDR_W{1'b0}};
            hl            <= 1'b0;
            data_write    <= 8'h00;
`ifdef INSTR_DECODE_ERR_EN
            err           <= 1'b0;
`endif
        end else begin
            byte_sync_q_r <= byte_sync;
            read          <= 1'b0;
            write         <= 1'b0;
            if (cs_n) begin
                // Abort beats any coincident byte; addr/hl are left as last decoded.
                state_r  <= IDLE;
                data_out <= 8'h00;
`ifdef INSTR_DECODE_ERR_EN
                if (state_r == WR_DATA) begin
                    err <= 1'b1;
                end
`endif
            end else begin
                case (state_r)
                    IDLE: begin
                        if (ev_s) begin
                            addr  <= data_in[ADDR_W-1:0];
                            hl    <= data_in[6];
                            bad_r <= cmd_bad_s;
`ifdef INSTR_DECODE_ERR_EN
                            if (cmd_bad_s) begin
                                err <= 1'b1;
                            end
`endif
                            if (data_in[7]) begin
                                state_r <= WR_DATA;
                            end else begin
                                read    <= ~cmd_bad_s;
                                state_r <= RD_ISSUE;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (ev_s) begin
                            write      <= ~bad_r;
                            data_write <= data_in;
                            state_r    <= IDLE;
                        end
                    end
                    RD_ISSUE: begin
                        state_r <= RD_CAP;
                    end
                    RD_CAP: begin
                        data_out <= bad_r ? 8'h00 : data_read;
`ifdef INSTR_DECODE_ERR_EN
                        if (addr == {ADDR_W{1'b0}}) begin
                            data_out <= {7'b0000000, err};
                            err      <= 1'b0;
                        end
`endif
                        state_r <= RD_HOLD;
                    end
                    RD_HOLD: begin
                        // The dummy byte shifting our data out ends the read.
                        if (ev_s) begin
                            state_r <= IDLE;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_decode.sv
// Scoreboard bench for instr_decode: expected strobes are queued as bytes are driven and
// checked as the DUT raises read/write.
module tb_instr_decode;

    localparam int unsigned AW   = 6;
    localparam int unsigned AMAX = 15;

    typedef struct packed {
        logic          is_wr;
        logic [AW-1:0] addr;
        logic          hl;
        logic [7:0]    data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cs_n;
    logic          byte_sync;
    logic [7:0]    data_in;
    logic [7:0]    data_out;
    logic          read;
    logic          write;
    logic [AW-1:0] addr;
    logic          hl;
    logic [7:0]    data_write;
    logic [7:0]    data_read;
    logic [7:0]    rd_value;
`ifdef INSTR_DECODE_ERR_EN
    logic          err;
`endif

    int   tests_run    = 0;
    int   tests_failed = 0;
    exp_t exp_q[$];

    instr_decode #(.ADDR_W(AW), .ADDR_MAX(AMAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .cs_n       (cs_n),
        .byte_sync  (byte_sync),
        .data_in    (data_in),
        .data_out   (data_out),
        .read       (read),
        .write      (write),
        .addr       (addr),
        .hl         (hl),
        .data_write (data_write),
        .data_read  (data_read)
`ifdef INSTR_DECODE_ERR_EN
        ,
        .err        (err)
`endif
    );

    always #5 clk = ~clk;

    // Register-file model: data valid one cycle after read, junk otherwise.
    always_ff @(posedge clk) begin
        data_read <= read ? rd_value : 8'hEE;
    end

    task automatic push_exp(input logic is_wr, input logic [AW-1:0] a, input logic h, input logic [7:0] d);
        exp_t e;
        e.is_wr = is_wr;
        e.addr  = a;
        e.hl    = h;
        e.data  = d;
        exp_q.push_back(e);
    endtask

    // One clock: sample strobes on the falling edge, then step past the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (read && write) begin
            tests_run++;
            tests_failed++;
            $display("FAIL strobe_overlap read=%0b write=%0b required not both", read, write);
        end else if (read || write) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_strobe read=%0b write=%0b addr=%0d required no strobe", read, write, addr);
            end else begin
                e = exp_q.pop_front();
                if (write !== e.is_wr || addr !== e.addr || hl !== e.hl || (write && data_write !== e.data)) begin
                    tests_failed++;
                    $display("FAIL strobe_fields got wr=%0b addr=%0d hl=%0b data=%h required wr=%0b addr=%0d hl=%0b data=%h",
                             write, addr, hl, data_write, e.is_wr, e.addr, e.hl, e.data);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        data_in   = b;
        byte_sync = 1'b1;
        repeat (hold) cycle();
        byte_sync = 1'b0;
        cycle();
    endtask

    task automatic drain_check(input string name);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_missing_strobe pending=%0d required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s got=%h required=%h", name, got, want);
        end
    endtask

    task automatic frame_end();
        cs_n = 1'b1;
        cycle();
        cycle();
        cs_n = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        check8("reset_outputs", {data_out, data_write}, 16'h0000);
        check8("reset_strobes", {4'h0, read, write, hl, 1'b0}, 8'h00);
        check8("reset_addr", {2'b00, addr}, 8'h00);
`ifdef INSTR_DECODE_ERR_EN
        check8("reset_err", {7'b0, err}, 8'h00);
`endif
        rst = 1'b0;
        cycle();
        cs_n = 1'b0;
        cycle();
    endtask

    task automatic test_write();
        push_exp(1'b1, 6'd5, 1'b0, 8'hA5);
        send_byte(8'h85, 1);
        send_byte(8'hA5, 1);
        cycle();
        drain_check("write");
        frame_end();
    endtask

    task automatic test_read();
        rd_value = 8'h3C;
        push_exp(1'b0, 6'd3, 1'b1, 8'h00);
        data_in   = 8'h43;
        byte_sync = 1'b1;
        cycle();
        byte_sync = 1'b0;
        cycle();
        check8("read_not_early", data_out, 8'h00);
        cycle();
        check8("read_data_out", data_out, 8'h3C);
        check8("read_addr_hl", {1'b0, hl, addr}, {1'b0, 1'b1, 6'd3});
        send_byte(8'h00, 1);
        cycle();
        check8("read_held_dummy", data_out, 8'h3C);
        drain_check("read");
        cs_n = 1'b1;
        cycle();
        check8("read_cs_clear", data_out, 8'h00);
        cs_n = 1'b0;
        cycle();
    endtask

    task automatic test_stretched();
        push_exp(1'b1, 6'd10, 1'b0, 8'h5A);
        send_byte(8'h8A, 5);
        send_byte(8'h5A, 5);
        repeat (3) cycle();
        drain_check("stretched");
        frame_end();
    endtask

    task automatic test_abort();
        send_byte(8'h81, 1);
        cs_n = 1'b1;
        cycle();
        cycle();
        check8("abort_addr_held", {2'b00, addr}, 8'h01);
`ifdef INSTR_DECODE_ERR_EN
        check8("abort_err", {7'b0, err}, 8'h01);
`endif
        cs_n = 1'b0;
        cycle();
        push_exp(1'b1, 6'd2, 1'b0, 8'h11);
        send_byte(8'h82, 1);
        send_byte(8'h11, 1);
        cycle();
        drain_check("abort_next_frame");
        // A byte arriving together with cs_n high must be ignored.
        cs_n      = 1'b1;
        data_in   = 8'h85;
        byte_sync = 1'b1;
        cycle();
        byte_sync = 1'b0;
        cs_n      = 1'b0;
        cycle();
        rd_value = 8'h71;
        push_exp(1'b0, 6'd7, 1'b0, 8'h00);
        send_byte(8'h07, 1);
        cycle();
        check8("abort_ev_ignored", data_out, 8'h71);
        send_byte(8'h00, 1);
        drain_check("abort_ev");
        frame_end();
    endtask

    task automatic test_range();
        send_byte(8'h94, 1);
        send_byte(8'h55, 1);
        cycle();
        drain_check("range_write");
`ifdef INSTR_DECODE_ERR_EN
        check8("range_err_set", {7'b0, err}, 8'h01);
`endif
        rd_value = 8'h3C;
        push_exp(1'b0, 6'd3, 1'b0, 8'h00);
        send_byte(8'h03, 1);
        cycle();
        send_byte(8'h00, 1);
        send_byte(8'h14, 1);
        cycle();
        check8("range_read_zero", data_out, 8'h00);
        send_byte(8'h00, 1);
        rd_value = 8'h5E;
        push_exp(1'b0, 6'd0, 1'b0, 8'h00);
        send_byte(8'h00, 1);
        cycle();
`ifdef INSTR_DECODE_ERR_EN
        check8("range_err_readback", data_out, 8'h01);
        check8("range_err_cleared", {7'b0, err}, 8'h00);
`else
        check8("range_addr0_read", data_out, 8'h5E);
`endif
        send_byte(8'h00, 1);
        drain_check("range_read");
        frame_end();
    endtask

    task automatic test_back_to_back();
        rd_value = 8'hB2;
        push_exp(1'b0, 6'd5, 1'b0, 8'h00);
        push_exp(1'b1, 6'd7, 1'b1, 8'h99);
        send_byte(8'h05, 1);
        cycle();
        send_byte(8'h00, 1);
        check8("b2b_read_data", data_out, 8'hB2);
        send_byte(8'hC7, 1);
        send_byte(8'h99, 1);
        cycle();
        drain_check("b2b");
    endtask

    task automatic test_reset_mid();
        rd_value = 8'h77;
        push_exp(1'b0, 6'd3, 1'b0, 8'h00);
        data_in   = 8'h03;
        byte_sync = 1'b1;
        cycle();
        byte_sync = 1'b0;
        cycle();
        rst = 1'b1;
        #1;
        check8("rst_async_data", data_out | data_write, 8'h00);
        check8("rst_async_ctl", {read, write, hl, 5'b00000} | {2'b00, addr}, 8'h00);
        rst = 1'b0;
        repeat (4) cycle();
        check8("rst_no_data", data_out, 8'h00);
        drain_check("rst_mid");
    endtask

    initial begin
        rst       = 1'b1;
        cs_n      = 1'b1;
        byte_sync = 1'b0;
        data_in   = 8'h00;
        rd_value  = 8'h00;
        #16;
        test_reset();
        test_write();
        test_read();
        test_stretched();
        test_abort();
        test_range();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
